// File: rtl/traffic_generator_gmii_core.sv
// GMII TX frame engine: preamble, SFD, fixed L2 header, pattern payload, CRC-32 FCS, inter-frame gap.
// Optional feature macro: TRAFFIC_GENERATOR_GMII_SEQNUM_EN (per-run sequence number in payload bytes 0..3).
module traffic_generator_gmii_core #(
   parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC       = 48'h000A_3500_0001,
   parameter logic [15:0] ETHERTYPE     = 16'h88B5,
   parameter int unsigned MIN_FRAME_LEN = 64,
   parameter int unsigned MAX_FRAME_LEN = 1518,
   parameter int unsigned MIN_IFG       = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ctrl_enable,
   input  logic [15:0] frame_len,
   input  logic [7:0]  ifg_len,
   input  logic [31:0] frame_limit,
   output logic [7:0]  gmii_txd,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic [31:0] frames_sent,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_FCS, S_IFG, S_DONE
   } state_t;

   localparam logic [111:0] HDR_BITS = {DST_MAC, SRC_MAC, ETHERTYPE};
   localparam logic [15:0]  MIN_LEN  = 16'(MIN_FRAME_LEN);
   localparam logic [15:0]  MAX_LEN  = 16'(MAX_FRAME_LEN);
   localparam logic [7:0]   MIN_GAP  = 8'(MIN_IFG);
   localparam logic [31:0]  CRC_POLY = 32'hEDB8_8320;

   // Reflected CRC-32, one data byte per call, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  ifg_q, ifg_d;
   logic [31:0] limit_q, limit_d;
   logic [31:0] run_cnt_q, run_cnt_d;
   logic [31:0] frames_sent_q, frames_sent_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  txd_q, txd_d;
   logic        tx_en_q, tx_en_d;

   logic [6:0]  hdr_idx;
   logic [7:0]  hdr_byte;
   logic [7:0]  pay_byte;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;
   logic [15:0] len_clamped;
   logic [7:0]  ifg_clamped;

   always_comb begin
      hdr_idx     = 7'd111 - {cnt_q[3:0], 3'b000};
      hdr_byte    = HDR_BITS[hdr_idx -: 8];
      fcs_word    = ~crc_q;
      fcs_byte    = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
`ifdef TRAFFIC_GENERATOR_GMII_SEQNUM_EN
      // Frames already completed in this run double as the sequence number.
      pay_byte    = (cnt_q < 16'd4) ? run_cnt_q[{~cnt_q[1:0], 3'b000} +: 8] : cnt_q[7:0];
`else
      pay_byte    = cnt_q[7:0];
`endif
      len_clamped = (frame_len < MIN_LEN) ? MIN_LEN :
                    (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
      ifg_clamped = (ifg_len < MIN_GAP) ? MIN_GAP : ifg_len;
   end

   always_comb begin
      // NOTE: every _d defaults to its hold value first, so no branch can infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q + 16'd1;
      len_d         = len_q;
      ifg_d         = ifg_q;
      limit_d       = limit_q;
      run_cnt_d     = run_cnt_q;
      frames_sent_d = frames_sent_q;
      crc_d         = crc_q;
      txd_d         = 8'h00;
      tx_en_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = 16'd0;
            if (ctrl_enable) begin
               state_d   = S_PRE;
               len_d     = len_clamped;
               ifg_d     = ifg_clamped;
               limit_d   = frame_limit;
               run_cnt_d = 32'd0;
            end
         end
         S_PRE: begin
            txd_d   = 8'h55;
            tx_en_d = 1'b1;
            if (cnt_q == 16'd6) begin
               state_d = S_SFD;
               cnt_d   = 16'd0;
            end
         end
         S_SFD: begin
            txd_d   = 8'hD5;
            tx_en_d = 1'b1;
            crc_d   = '1;
            state_d = S_HDR;
            cnt_d   = 16'd0;
         end
         S_HDR: begin
            txd_d   = hdr_byte;
            tx_en_d = 1'b1;
            crc_d   = crc_byte(crc_q, hdr_byte);
            if (cnt_q == 16'd13) begin
               state_d = S_PAY;
               cnt_d   = 16'd0;
            end
         end
         S_PAY: begin
            txd_d   = pay_byte;
            tx_en_d = 1'b1;
            crc_d   = crc_byte(crc_q, pay_byte);
            // Payload is frame_len minus 14 header and 4 FCS bytes.
            if (cnt_q == len_q - 16'd19) begin
               state_d = S_FCS;
               cnt_d   = 16'd0;
            end
         end
         S_FCS: begin
            txd_d   = fcs_byte;
            tx_en_d = 1'b1;
            if (cnt_q == 16'd3) begin
               state_d       = S_IFG;
               cnt_d         = 16'd0;
               run_cnt_d     = run_cnt_q + 32'd1;
               frames_sent_d = frames_sent_q + 32'd1;
            end
         end
         S_IFG: begin
            if (cnt_q == {8'h00, ifg_q} - 16'd1) begin
               cnt_d = 16'd0;
               // Limit check comes first so a simultaneous enable drop still lands in DONE.
               if ((limit_q != 32'd0) && (run_cnt_q == limit_q)) state_d = S_DONE;
               else if (ctrl_enable)                               state_d = S_PRE;
               else                                                state_d = S_IDLE;
            end
         end
         S_DONE: begin
            cnt_d = 16'd0;
            if (!ctrl_enable) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= 16'd0;
         len_q         <= 16'd0;
         ifg_q         <= 8'd0;
         limit_q       <= 32'd0;
         run_cnt_q     <= 32'd0;
         frames_sent_q <= 32'd0;
         crc_q         <= 32'd0;
         txd_q         <= 8'h00;
         tx_en_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         ifg_q         <= ifg_d;
         limit_q       <= limit_d;
         run_cnt_q     <= run_cnt_d;
         frames_sent_q <= frames_sent_d;
         crc_q         <= crc_d;
         txd_q         <= txd_d;
         tx_en_q       <= tx_en_d;
      end
   end

   assign gmii_txd    = txd_q;
   assign gmii_tx_en  = tx_en_q;
   assign gmii_tx_er  = 1'b0;
   assign frames_sent = frames_sent_q;
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_traffic_generator_gmii_core.sv
// Self-checking bench for traffic_generator_gmii_core: a wire monitor captures bursts and gaps,
// and a frame model built from the Ethernet framing rules supplies every expected byte.
module tb_traffic_generator_gmii_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        ctrl_enable;
   logic [15:0] frame_len;
   logic [7:0]  ifg_len;
   logic [31:0] frame_limit;
   logic [7:0]  gmii_txd;
   logic        gmii_tx_en;
   logic        gmii_tx_er;
   logic [31:0] frames_sent;
   logic        busy;

   traffic_generator_gmii_core dut (
      .clk         (clk),
      .reset       (reset),
      .ctrl_enable (ctrl_enable),
      .frame_len   (frame_len),
      .ifg_len     (ifg_len),
      .frame_limit (frame_limit),
      .gmii_txd    (gmii_txd),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_tx_er  (gmii_tx_er),
      .frames_sent (frames_sent),
      .busy        (busy)
   );

   always #4 clk = ~clk;

`ifdef TRAFFIC_GENERATOR_GMII_SEQNUM_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   // Wire monitor state, written only by the monitor process.
   logic [7:0] rx_bytes[$];
   int         rx_start[$];
   int         rx_lens[$];
   int         rx_gaps[$];
   int         cur_len   = 0;
   int         idle_run  = 0;
   int         er_count  = 0;
   int         idle_bad  = 0;
   bit         in_frame  = 1'b0;
   bit         seen_reset = 1'b0;

   logic [7:0] exp_q[$];

   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1) seen_reset = 1'b1;
         if (seen_reset) begin
            if (gmii_tx_er !== 1'b0) er_count++;
            if (gmii_tx_en === 1'b1) begin
               if (!in_frame) begin
                  rx_start.push_back(rx_bytes.size());
                  rx_gaps.push_back(idle_run);
                  in_frame = 1'b1;
                  cur_len  = 0;
               end
               rx_bytes.push_back(gmii_txd);
               cur_len++;
               idle_run = 0;
            end else begin
               if (gmii_txd !== 8'h00) idle_bad++;
               if (in_frame) begin
                  rx_lens.push_back(cur_len);
                  in_frame = 1'b0;
               end
               idle_run++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Bit-at-a-time reflected CRC-32 update.
   function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   function automatic int clamp_len(input int l);
      return (l < 64) ? 64 : ((l > 1518) ? 1518 : l);
   endfunction

   function automatic int clamp_ifg(input int g);
      return (g < 12) ? 12 : g;
   endfunction

   // Full on-wire frame: preamble, SFD, DA, SA, type, payload, FCS (LSB byte first).
   task automatic build_expected(input int len, input int unsigned seq);
      logic [111:0] hdr;
      logic [31:0]  crc;
      logic [7:0]   b;
      exp_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      hdr = {48'hFFFF_FFFF_FFFF, 48'h000A_3500_0001, 16'h88B5};
      for (int i = 0; i < 14; i++) exp_q.push_back(hdr[111 - 8 * i -: 8]);
      for (int k = 0; k < len - 18; k++) begin
         b = 8'(k % 256);
         if (SEQ_EN && k < 4) b = 8'(seq >> (24 - 8 * k));
         exp_q.push_back(b);
      end
      crc = 32'hFFFF_FFFF;
      for (int i = 8; i < exp_q.size(); i++) crc = crc_bits(crc, exp_q[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) exp_q.push_back(crc[8 * i +: 8]);
   endtask

   task automatic check_frame(input int idx, input int len, input int unsigned seq, input string tag);
      int          mism;
      int          n;
      int          st;
      logic [31:0] crc;
      build_expected(len, seq);
      n  = rx_lens[idx];
      st = rx_start[idx];
      check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
      mism = 0;
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         if (rx_bytes[st + i] !== exp_q[i]) mism++;
      end
      check({tag, "_bad_bytes"}, 32'(mism), 32'd0);
      crc = 32'hFFFF_FFFF;
      for (int i = 8; i < n; i++) crc = crc_bits(crc, rx_bytes[st + i]);
      check({tag, "_residue"}, crc, 32'hDEBB_20E3);
   endtask

   task automatic wait_not_busy(input int budget, input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_busy_timeout"}, {31'd0, busy === 1'b1}, 32'd0);
   endtask

   // One limited run; inputs are scrambled after the start edge and must be ignored.
   task automatic run_limited(input int len_in, input int ifg_in, input int limit, input string tag);
      int          base;
      int          eff_len;
      int          eff_ifg;
      logic [31:0] sent0;
      base    = rx_lens.size();
      sent0   = frames_sent;
      eff_len = clamp_len(len_in);
      eff_ifg = clamp_ifg(ifg_in);
      frame_len   = 16'(len_in);
      ifg_len     = 8'(ifg_in);
      frame_limit = 32'(limit);
      ctrl_enable = 1'b1;
      @(posedge clk); #1;
      frame_len   = 16'($urandom);
      ifg_len     = 8'($urandom);
      frame_limit = $urandom;
      wait_not_busy(limit * (eff_len + eff_ifg + 12) + 100, tag);
      repeat (5) @(posedge clk);
      #1;
      check({tag, "_frames"}, 32'(rx_lens.size() - base), 32'(limit));
      for (int i = 0; i < limit; i++) begin
         if (base + i < rx_lens.size()) begin
            check_frame(base + i, eff_len, i, tag);
            if (i > 0) check({tag, "_ifg"}, 32'(rx_gaps[base + i]), 32'(eff_ifg));
         end
      end
      check({tag, "_frames_sent"}, frames_sent, sent0 + 32'(limit));
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      ctrl_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int          base;
      int          n;
      logic [31:0] sent0;

      // Reset state.
      reset = 1'b1; ctrl_enable = 1'b0;
      frame_len = 16'd64; ifg_len = 8'd12; frame_limit = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", {24'd0, gmii_txd}, 32'd0);
      check("rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
      check("rst_tx_er", {31'd0, gmii_tx_er}, 32'd0);
      check("rst_frames_sent", frames_sent, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single minimum frame with start latency, then DONE held while enable stays high.
      ctrl_enable = 1'b1;
      @(posedge clk); #1;
      check("lat_n_tx_en", {31'd0, gmii_tx_en}, 32'd0);
      check("lat_n_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      check("lat_n1_tx_en", {31'd0, gmii_tx_en}, 32'd1);
      check("lat_n1_txd", {24'd0, gmii_txd}, 32'h55);
      wait_not_busy(500, "t1");
      repeat (100) @(posedge clk);
      #1;
      check("t1_frames", 32'(rx_lens.size()), 32'd1);
      if (rx_lens.size() > 0) check_frame(0, 64, 0, "t1");
      check("t1_frames_sent", frames_sent, 32'd1);
      check("t1_done_busy", {31'd0, busy}, 32'd0);
      ctrl_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // FCS residue across lengths, and clamps at both ends.
      run_limited(65, 12, 1, "len65");
      run_limited(1518, 12, 1, "len1518");
      run_limited(20, 3, 2, "clamp_lo");
      run_limited(2000, 40, 1, "clamp_hi");
      for (int r = 0; r < 3; r++) begin
         run_limited($urandom_range(40, 1600), $urandom_range(0, 30), $urandom_range(1, 3), "rand");
      end
`ifdef TRAFFIC_GENERATOR_GMII_SEQNUM_EN
      run_limited(64, 12, 3, "seqnum");
`endif

      // Continuous run, enable dropped mid frame 3: frame and its gap complete, then IDLE.
      base  = rx_lens.size();
      sent0 = frames_sent;
      frame_len = 16'd64; ifg_len = 8'd12; frame_limit = 32'd0;
      ctrl_enable = 1'b1;
      n = 0;
      while (!(rx_lens.size() == base + 2 && in_frame && cur_len >= 30) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("cont_wait_timeout", {31'd0, n >= 1000}, 32'd0);
      ctrl_enable = 1'b0;
      wait_not_busy(300, "cont");
      repeat (50) @(posedge clk);
      #1;
      check("cont_frames", 32'(rx_lens.size() - base), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (base + i < rx_lens.size()) begin
            check_frame(base + i, 64, i, "cont");
            if (i > 0) check("cont_ifg", 32'(rx_gaps[base + i]), 32'd12);
         end
      end
      check("cont_frames_sent", frames_sent, sent0 + 32'd3);
      check("cont_tx_en_idle", {31'd0, gmii_tx_en}, 32'd0);

      // Reset pulsed while payload byte 10 is on the wire.
      base = rx_lens.size();
      frame_limit = 32'd0;
      ctrl_enable = 1'b1;
      n = 0;
      while (!(in_frame && rx_lens.size() == base && cur_len == 32) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_wait_timeout", {31'd0, n >= 500}, 32'd0);
      check("mid_pay_byte10", {24'd0, gmii_txd}, 32'h0A);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
      check("mid_rst_txd", {24'd0, gmii_txd}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_frames_sent", frames_sent, 32'd0);
      frame_limit = 32'd1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("mid_restart_n_tx_en", {31'd0, gmii_tx_en}, 32'd0);
      @(posedge clk); #1;
      check("mid_restart_tx_en", {31'd0, gmii_tx_en}, 32'd1);
      check("mid_restart_txd", {24'd0, gmii_txd}, 32'h55);
      wait_not_busy(500, "mid");
      repeat (5) @(posedge clk);
      #1;
      check("mid_frames", 32'(rx_lens.size() - base), 32'd2);
      if (rx_lens.size() > base) check("mid_trunc_len", 32'(rx_lens[base]), 32'd33);
      if (rx_lens.size() > base + 1) check_frame(base + 1, 64, 0, "mid_fresh");
      check("mid_frames_sent", frames_sent, 32'd1);
      ctrl_enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      check("tx_er_always_zero", 32'(er_count), 32'd0);
      check("idle_txd_zero", 32'(idle_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
